// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the work-RAM arbiter: FSM states, port ids, round-robin pick.
// No logic of its own; imported by the arbiter and its bench.
// The pick helper is purely combinational.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_READ   = 2'd2
    } arb_state_e;

    typedef logic arb_port_t;

    localparam arb_port_t ARB_PORT_A = 1'b0;
    localparam arb_port_t ARB_PORT_B = 1'b1;

    // Round-robin choice: a lone eligible port wins; on contention the port
    // that was not granted last time wins.
    function automatic arb_port_t rr_pick(input logic a_elig,
                                          input logic b_elig,
                                          input arb_port_t last_grant);
        arb_port_t pick;
        if (a_elig && b_elig) begin
            pick = (last_grant == ARB_PORT_A) ? ARB_PORT_B : ARB_PORT_A;
        end else if (a_elig) begin
            pick = ARB_PORT_A;
        end else begin
            pick = ARB_PORT_B;
        end
        return pick;
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between CPU (A) and DMA (B).
// Latency from eligible IDLE cycle: write ack in cycle 2, read ack + data in cycle 3.
// Requesters hold fields until ack; a port is never re-granted in its own ack cycle.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  a_req,
    input  logic                  a_wr,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wr_data,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rd_data,

    input  logic                  b_req,
    input  logic                  b_wr,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wr_data,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rd_data,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_wr_en,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,

    output logic                  busy
);

    arb_state_e            state_q;
    arb_port_t             grant_q;
    arb_port_t             last_grant_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] ram_wr_data_q;
    logic                  ram_wr_en_q;
    logic                  a_ack_q;
    logic                  b_ack_q;
    logic [DATA_WIDTH-1:0] a_rd_data_q;
    logic [DATA_WIDTH-1:0] b_rd_data_q;

    logic                  a_elig;
    logic                  b_elig;
    logic                  any_elig;
    arb_port_t             grant_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wr_data_d;
    logic                  wr_d;

    // Eligibility excludes the ack cycle (fields are stale there); select the winner's fields.
    always_comb begin
        a_elig    = a_req && !a_ack_q;
        b_elig    = b_req && !b_ack_q;
        any_elig  = a_elig || b_elig;
        grant_d   = rr_pick(a_elig, b_elig, last_grant_q);
        addr_d    = (grant_d == ARB_PORT_A) ? a_addr    : b_addr;
        wr_data_d = (grant_d == ARB_PORT_A) ? a_wr_data : b_wr_data;
        wr_d      = (grant_d == ARB_PORT_A) ? a_wr      : b_wr;
    end

    // Arbitration FSM with registered RAM controls, acks and read-data holding registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ARB_IDLE;
            grant_q       <= ARB_PORT_A;
            last_grant_q  <= ARB_PORT_B;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
            ram_wr_en_q   <= 1'b0;
            a_ack_q       <= 1'b0;
            b_ack_q       <= 1'b0;
            a_rd_data_q   <= '0;
            b_rd_data_q   <= '0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (any_elig) begin
                        state_q       <= ARB_ACCESS;
                        grant_q       <= grant_d;
                        last_grant_q  <= grant_d;
                        ram_addr_q    <= addr_d;
                        ram_wr_data_q <= wr_data_d;
                        ram_wr_en_q   <= wr_d;
                    end
                end
                ARB_ACCESS: begin
                    // RAM samples address/data at the end of this cycle.
                    if (ram_wr_en_q) begin
                        ram_wr_en_q <= 1'b0;
                        state_q     <= ARB_IDLE;
                        if (grant_q == ARB_PORT_A) begin
                            a_ack_q <= 1'b1;
                        end else begin
                            b_ack_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ARB_READ;
                    end
                end
                ARB_READ: begin
                    state_q <= ARB_IDLE;
                    if (grant_q == ARB_PORT_A) begin
                        a_rd_data_q <= ram_rd_data;
                        a_ack_q     <= 1'b1;
                    end else begin
                        b_rd_data_q <= ram_rd_data;
                        b_ack_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ARB_IDLE;
                    ram_wr_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_wr_data = ram_wr_data_q;
    assign ram_wr_en   = ram_wr_en_q;
    assign a_ack       = a_ack_q;
    assign b_ack       = b_ack_q;
    assign a_rd_data   = a_rd_data_q;
    assign b_rd_data   = b_rd_data_q;
    assign busy        = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level model plus per-cycle compare and directed literal checks.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A behavioural single-port RAM with 1-cycle registered read sits on the RAM side.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        a_req, a_wr, b_req, b_wr;
    logic [15:0] a_addr, b_addr;
    logic [7:0]  a_wr_data, b_wr_data;
    logic        a_ack, b_ack;
    logic [7:0]  a_rd_data, b_rd_data;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wr_data;
    logic        ram_wr_en;
    logic [7:0]  ram_rd_data;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 0;

    ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wr_data(a_wr_data),
        .a_ack(a_ack), .a_rd_data(a_rd_data),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wr_data(b_wr_data),
        .b_ack(b_ack), .b_rd_data(b_rd_data),
        .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
        .ram_rd_data(ram_rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_addr];
    end

    // Transaction-level model: one transaction at a time, aged in cycles since grant.
    // A write finishes (acks) at age 2, a read at age 3; the ack cycle is idle.
    logic [7:0]  shadow [0:65535];
    bit          m_act = 0;
    logic        m_port = ARB_PORT_A;
    logic        m_last = ARB_PORT_B;
    bit          m_wr = 0;
    logic [15:0] m_addr = '0;
    logic [7:0]  m_wdata = '0;
    logic [7:0]  m_a_rd = '0, m_b_rd = '0;
    int          m_age = 0;
    int          m_len = 0;
    bit          t_idle, t_aack, t_back, t_ael, t_bel;
    logic        t_pick;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_act   <= 0;
            m_port  <= ARB_PORT_A;
            m_last  <= ARB_PORT_B;
            m_wr    <= 0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_a_rd  <= '0;
            m_b_rd  <= '0;
            m_age   <= 0;
            m_len   <= 0;
        end else begin
            t_idle = !m_act || (m_age >= m_len);
            t_aack = m_act && (m_age == m_len) && (m_port == ARB_PORT_A);
            t_back = m_act && (m_age == m_len) && (m_port == ARB_PORT_B);
            t_ael  = a_req && !t_aack;
            t_bel  = b_req && !t_back;
            if (t_idle && (t_ael || t_bel)) begin
                if (t_ael && t_bel) t_pick = (m_last == ARB_PORT_A) ? ARB_PORT_B : ARB_PORT_A;
                else                t_pick = t_ael ? ARB_PORT_A : ARB_PORT_B;
                m_act   <= 1;
                m_age   <= 1;
                m_port  <= t_pick;
                m_last  <= t_pick;
                m_wr    <= (t_pick == ARB_PORT_A) ? a_wr : b_wr;
                m_len   <= ((t_pick == ARB_PORT_A) ? a_wr : b_wr) ? 2 : 3;
                m_addr  <= (t_pick == ARB_PORT_A) ? a_addr : b_addr;
                m_wdata <= (t_pick == ARB_PORT_A) ? a_wr_data : b_wr_data;
            end else if (!t_idle) begin
                m_age <= m_age + 1;
                if (m_wr && (m_age + 1 == 2)) shadow[m_addr] <= m_wdata;
                if (!m_wr && (m_age + 1 == 3)) begin
                    if (m_port == ARB_PORT_A) m_a_rd <= shadow[m_addr];
                    else                      m_b_rd <= shadow[m_addr];
                end
            end else begin
                m_act <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_ram_addr",  32'(ram_addr),    32'(m_addr));
            check("cyc_ram_wdata", 32'(ram_wr_data), 32'(m_wdata));
            check("cyc_ram_wr_en", 32'(ram_wr_en),   32'(m_act && m_wr && m_age == 1));
            check("cyc_busy",      32'(busy),        32'(m_act && m_age < m_len));
            check("cyc_a_ack",     32'(a_ack),       32'(m_act && m_age == m_len && m_port == ARB_PORT_A));
            check("cyc_b_ack",     32'(b_ack),       32'(m_act && m_age == m_len && m_port == ARB_PORT_B));
            check("cyc_a_rd",      32'(a_rd_data),   32'(m_a_rd));
            check("cyc_b_rd",      32'(b_rd_data),   32'(m_b_rd));
        end
    end

    task automatic drive(input logic port, input logic wr, input logic [15:0] addr, input logic [7:0] data);
        if (port == ARB_PORT_A) begin
            a_req = 1; a_wr = wr; a_addr = addr; a_wr_data = data;
        end else begin
            b_req = 1; b_wr = wr; b_addr = addr; b_wr_data = data;
        end
    endtask

    // Waits for ack on every port requesting now; drops req in its ack cycle. -1 = timeout.
    task automatic wait_acks(input int c0, output int la, output int lb);
        bit need_a, need_b;
        need_a = a_req;
        need_b = b_req;
        la = -1;
        lb = -1;
        for (int n = 0; n < 40 && ((need_a && la < 0) || (need_b && lb < 0)); n++) begin
            @(negedge clk);
            if (a_ack && la < 0) begin la = cyc - c0; a_req = 0; end
            if (b_ack && lb < 0) begin lb = cyc - c0; b_req = 0; end
        end
    endtask

    task automatic single(input logic port, input logic wr, input logic [15:0] addr,
                          input logic [7:0] data, output int lat);
        int c0, la, lb;
        @(negedge clk);
        c0 = cyc;
        drive(port, wr, addr, data);
        wait_acks(c0, la, lb);
        lat = (port == ARB_PORT_A) ? la : lb;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
    endtask

    int lat, la, lb, c0, na, nb, lastb, busy_cnt;
    int order[$];

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]    = 8'h00;
            shadow[i] = 8'h00;
        end
        clk = 0; reset_n = 1;
        a_req = 0; a_wr = 0; a_addr = '0; a_wr_data = '0;
        b_req = 0; b_wr = 0; b_addr = '0; b_wr_data = '0;
        #3 reset_n = 0;
        repeat (2) @(negedge clk);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_wr_en",    32'(ram_wr_en), 0);
        check("rst_wdata",    32'(ram_wr_data), 0);
        check("rst_busy",     32'(busy), 0);
        check("rst_acks",     32'({a_ack, b_ack}), 0);
        check("rst_rd",       32'({a_rd_data, b_rd_data}), 0);
        reset_n = 1;
        chk_en  = 1;

        // Single write A, then read-back
        @(negedge clk);
        c0 = cyc;
        drive(ARB_PORT_A, 1, 16'h1234, 8'hA5);
        @(negedge clk);
        check("w1_wr_en_c1", 32'(ram_wr_en), 1);
        check("w1_addr_c1",  32'(ram_addr), 32'h1234);
        @(negedge clk);
        check("w1_ack_c2",   32'(a_ack), 1);
        check("w1_wr_en_c2", 32'(ram_wr_en), 0);
        a_req = 0;
        single(ARB_PORT_A, 0, 16'h1234, 8'h00, lat);
        check("r1_lat", lat, 3);
        check("r1_data", 32'(a_rd_data), 32'hA5);

        // Simultaneous reads after reset: A first, B granted in A's ack cycle
        pulse_reset();
        @(negedge clk);
        c0 = cyc;
        drive(ARB_PORT_A, 0, 16'h0010, 8'h00);
        drive(ARB_PORT_B, 0, 16'h0020, 8'h00);
        wait_acks(c0, la, lb);
        check("both_a_lat", la, 3);
        check("both_b_lat", lb, 6);

        // 8 back-to-back writes per port: strict alternation
        @(negedge clk);
        c0 = cyc; na = 0; nb = 0; lastb = -1;
        order.delete();
        drive(ARB_PORT_A, 1, 16'h0100, 8'h10);
        drive(ARB_PORT_B, 1, 16'h0200, 8'h80);
        for (int n = 0; n < 80 && (na < 8 || nb < 8); n++) begin
            @(negedge clk);
            if (a_ack) begin
                order.push_back(0);
                na++;
                if (na < 8) drive(ARB_PORT_A, 1, 16'h0100 + 16'(na), 8'h10 + 8'(na));
                else        a_req = 0;
            end
            if (b_ack) begin
                order.push_back(1);
                nb++;
                lastb = cyc - c0;
                if (nb < 8) drive(ARB_PORT_B, 1, 16'h0200 + 16'(nb), 8'h80 + 8'(nb));
                else        b_req = 0;
            end
        end
        check("bb_count", order.size(), 16);
        foreach (order[i]) check("bb_order", order[i], i % 2);
        check("bb_last_b_lat", lastb, 32);

        // B drops req in cycle 1 of a read: still completes, no regrant
        @(negedge clk);
        c0 = cyc;
        drive(ARB_PORT_B, 0, 16'h0201, 8'h00);
        @(negedge clk);
        b_req = 0;
        lb = -1;
        for (int n = 0; n < 10 && lb < 0; n++) begin
            @(negedge clk);
            if (b_ack) lb = cyc - c0;
        end
        check("bdrop_lat", lb, 3);
        check("bdrop_data", 32'(b_rd_data), 32'h81);
        busy_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("bdrop_no_regrant", busy_cnt, 0);

        // Reset during ACCESS of a write
        @(negedge clk);
        drive(ARB_PORT_A, 1, 16'h0055, 8'h77);
        @(posedge clk);
        #2 reset_n = 0;
        a_req = 0;
        #1;
        check("rmid_wr_en", 32'(ram_wr_en), 0);
        check("rmid_busy",  32'(busy), 0);
        check("rmid_addr",  32'(ram_addr), 0);
        repeat (2) begin
            @(negedge clk);
            check("rmid_ack", 32'({a_ack, b_ack}), 0);
        end
        reset_n = 1;
        single(ARB_PORT_A, 0, 16'h0055, 8'h00, lat);
        check("rmid_nowrite_lat", lat, 3);
        check("rmid_nowrite_data", 32'(a_rd_data), 0);
        single(ARB_PORT_A, 1, 16'h0055, 8'h77, lat);
        check("rpost_w_lat", lat, 2);
        single(ARB_PORT_A, 0, 16'h0055, 8'h00, lat);
        check("rpost_r_lat", lat, 3);
        check("rpost_r_data", 32'(a_rd_data), 32'h77);

        // A writes, B reads same location; A's read data untouched
        single(ARB_PORT_A, 1, 16'h00FF, 8'h5A, lat);
        check("x_w_lat", lat, 2);
        single(ARB_PORT_B, 0, 16'h00FF, 8'h00, lat);
        check("x_r_lat", lat, 3);
        check("x_b_rd", 32'(b_rd_data), 32'h5A);
        check("x_a_hold", 32'(a_rd_data), 32'h77);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
